traffic_light_controller: RTL and testbench

TRAFFIC_LIGHT_CONTROLLER -- requirements
Module: traffic_light_controller

---
 rtl/traffic_light_controller.sv | 118 +++++++++++
 tb/tb_traffic_light_controller.sv | 132 +++++++++++++
 2 files changed

// File: rtl/traffic_light_controller.sv
// Two-direction traffic light controller with traffic-adaptive green time.
// Optional all-red clearance phases are enabled with `define ALL_RED_CLEARANCE_EN;
// without it the CLEAR states are skipped and yellow hands over directly.
module traffic_light_controller #(
  parameter int unsigned GREEN_LOW    = 5,
  parameter int unsigned GREEN_MOD    = 10,
  parameter int unsigned GREEN_HIGH   = 15,
  parameter int unsigned YELLOW_TIME  = 3,
  parameter int unsigned ALL_RED_TIME = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] traffic_NS,
  input  logic [1:0] traffic_EW,
  output logic [1:0] NS_light,
  output logic [1:0] EW_light
);

  localparam int unsigned TW = 8;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;

  // Durations below 1 are illegal; clamp them so the timer compare never underflows.
  localparam logic [TW-1:0] G_LOW  = (GREEN_LOW    < 1) ? TW'(1) : TW'(GREEN_LOW);
  localparam logic [TW-1:0] G_MOD  = (GREEN_MOD    < 1) ? TW'(1) : TW'(GREEN_MOD);
  localparam logic [TW-1:0] G_HIGH = (GREEN_HIGH   < 1) ? TW'(1) : TW'(GREEN_HIGH);
  localparam logic [TW-1:0] Y_DUR  = (YELLOW_TIME  < 1) ? TW'(1) : TW'(YELLOW_TIME);
  localparam logic [TW-1:0] R_DUR  = (ALL_RED_TIME < 1) ? TW'(1) : TW'(ALL_RED_TIME);

  typedef enum logic [2:0] {
    NS_GREEN,
    NS_YELLOW,
    NS_CLEAR,
    EW_GREEN,
    EW_YELLOW,
    EW_CLEAR
  } state_t;

  state_t        state;
  state_t        nxt;
  logic [TW-1:0] timer;
  logic [TW-1:0] target;
  logic [TW-1:0] dur;

  // Traffic level to green duration; level 11 is treated as high.
  function automatic logic [TW-1:0] level_dur(input logic [1:0] lvl);
    case (lvl)
      2'b00:   return G_LOW;
      2'b01:   return G_MOD;
      default: return G_HIGH;
    endcase
  endfunction

  // Lamp pattern {NS, EW} shown while in a given state.
  function automatic logic [3:0] lamps(input state_t s);
    case (s)
      NS_GREEN:  return {GREEN,  RED};
      NS_YELLOW: return {YELLOW, RED};
      EW_GREEN:  return {RED,    GREEN};
      EW_YELLOW: return {RED,    YELLOW};
      default:   return {RED,    RED};
    endcase
  endfunction

  // Dwell length of the current state; greens use the latched target.
  always_comb begin
    dur = target;
    case (state)
      NS_YELLOW, EW_YELLOW: dur = Y_DUR;
      NS_CLEAR, EW_CLEAR:   dur = R_DUR;
      default:              dur = target;
    endcase
  end

  // Successor state in the fixed phase rotation.
  always_comb begin
    nxt = NS_GREEN;
    case (state)
      NS_GREEN:  nxt = NS_YELLOW;
`ifdef ALL_RED_CLEARANCE_EN
      NS_YELLOW: nxt = NS_CLEAR;
      EW_YELLOW: nxt = EW_CLEAR;
`else
      NS_YELLOW: nxt = EW_GREEN;
      EW_YELLOW: nxt = NS_GREEN;
`endif
      NS_CLEAR:  nxt = EW_GREEN;
      EW_GREEN:  nxt = EW_YELLOW;
      EW_CLEAR:  nxt = NS_GREEN;
      default:   nxt = NS_GREEN;
    endcase
  end

  // Phase sequencer: dwell timer, green target latch and registered lamp outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= NS_GREEN;
      timer    <= '0;
      target   <= G_LOW;
      NS_light <= GREEN;
      EW_light <= RED;
    end else if (timer == dur - TW'(1)) begin
      state                <= nxt;
      timer                <= '0;
      {NS_light, EW_light} <= lamps(nxt);
      if (nxt == NS_GREEN) begin
        target <= level_dur(traffic_NS);
      end else if (nxt == EW_GREEN) begin
        target <= level_dur(traffic_EW);
      end
    end else begin
      timer <= timer + TW'(1);
    end
  end

endmodule

// File: tb/tb_traffic_light_controller.sv
// Bench for traffic_light_controller: phase lengths per traffic pattern,
// green latching, lamp exclusivity and asynchronous reset behaviour.
module tb_traffic_light_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] traffic_NS;
  logic [1:0] traffic_EW;
  logic [1:0] NS_light;
  logic [1:0] EW_light;

  int n_cmp = 0;
  int n_err = 0;

  traffic_light_controller dut (
    .clk        (clk),
    .rst        (rst),
    .traffic_NS (traffic_NS),
    .traffic_EW (traffic_EW),
    .NS_light   (NS_light),
    .EW_light   (EW_light)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] tns;
    logic [1:0] tew;
    int         ns_green;
    int         ew_green;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Counts consecutive post-edge samples showing the given lamp pair.
  task automatic run_phase(input string name, input logic [1:0] ens, input logic [1:0] eew,
                           input int exp_len, input int chg_at, input logic [1:0] chg_ew);
    int cnt;
    cnt = 0;
    while (NS_light == ens && EW_light == eew && cnt < 300) begin
      n_cmp++;
      if (NS_light != 2'b00 && EW_light != 2'b00) begin
        n_err++;
        $display("FAIL %s exclusive: NS=%b EW=%b both non-red", name, NS_light, EW_light);
      end
      cnt++;
      if (cnt == chg_at) traffic_EW = chg_ew;
      @(posedge clk); #1;
    end
    check(name, cnt, exp_len);
  endtask

  task automatic run_period(input string tag, input int ns_len, input int ew_len,
                            input int chg_at, input logic [1:0] chg_ew);
    run_phase({tag, " ns_green"},  2'b10, 2'b00, ns_len, -1, 2'b00);
    run_phase({tag, " ns_yellow"}, 2'b01, 2'b00, 3, -1, 2'b00);
`ifdef ALL_RED_CLEARANCE_EN
    run_phase({tag, " ns_clear"},  2'b00, 2'b00, 1, -1, 2'b00);
`endif
    run_phase({tag, " ew_green"},  2'b00, 2'b10, ew_len, chg_at, chg_ew);
    run_phase({tag, " ew_yellow"}, 2'b00, 2'b01, 3, -1, 2'b00);
`ifdef ALL_RED_CLEARANCE_EN
    run_phase({tag, " ew_clear"},  2'b00, 2'b00, 1, -1, 2'b00);
`endif
  endtask

  // Holds reset across an edge, checks reset lamps, releases at a sample point.
  task automatic do_reset(input logic [1:0] tns, input logic [1:0] tew);
    traffic_NS = tns;
    traffic_EW = tew;
    rst = 1'b1;
    @(posedge clk); #1;
    check("reset lamps", int'({NS_light, EW_light}), int'(4'b1000));
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    traffic_NS = 2'b00;
    traffic_EW = 2'b00;

    vecs[0] = '{tns: 2'b00, tew: 2'b00, ns_green: 5,  ew_green: 5};
    vecs[1] = '{tns: 2'b01, tew: 2'b00, ns_green: 10, ew_green: 5};
    vecs[2] = '{tns: 2'b00, tew: 2'b10, ns_green: 5,  ew_green: 15};
    vecs[3] = '{tns: 2'b11, tew: 2'b11, ns_green: 15, ew_green: 15};
    vecs[4] = '{tns: 2'b10, tew: 2'b01, ns_green: 15, ew_green: 10};

    #2;
    check("async reset lamps", int'({NS_light, EW_light}), int'(4'b1000));

    // First NS green after reset always uses the reset target.
    for (int i = 0; i < 5; i++) begin
      do_reset(vecs[i].tns, vecs[i].tew);
      run_period($sformatf("v%0d p1", i), 5, vecs[i].ew_green, -1, 2'b00);
      run_period($sformatf("v%0d p2", i), vecs[i].ns_green, vecs[i].ew_green, -1, 2'b00);
    end

    // EW traffic drops mid-green: current green keeps 15, next EW green is 5.
    do_reset(2'b00, 2'b10);
    run_period("chg p1", 5, 15, 4, 2'b00);
    run_period("chg p2", 5, 5, -1, 2'b00);

    // Reset pulse in the middle of EW yellow.
    do_reset(2'b00, 2'b00);
    run_phase("ry ns_green",  2'b10, 2'b00, 5, -1, 2'b00);
    run_phase("ry ns_yellow", 2'b01, 2'b00, 3, -1, 2'b00);
`ifdef ALL_RED_CLEARANCE_EN
    run_phase("ry ns_clear",  2'b00, 2'b00, 1, -1, 2'b00);
`endif
    run_phase("ry ew_green",  2'b00, 2'b10, 5, -1, 2'b00);
    @(posedge clk); #1;
    check("mid ew_yellow lamps", int'({NS_light, EW_light}), int'(4'b0001));
    rst = 1'b1;
    #1;
    check("async mid reset lamps", int'({NS_light, EW_light}), int'(4'b1000));
    #9;
    rst = 1'b0;
    run_period("after rst", 5, 5, -1, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
